aes128_iter_enc_stream: RTL and testbench
=========================================

// Module: aes128_iter_enc_stream
// PURPOSE
//  Parametrised successor to the byte-serial AES-128 encrypt top: one full AES round per clock,
//  on-the-fly key expansion, valid/ready streaming. Input/output beat width is a parameter.
//  Sits between the byte/word ingress path and the ciphertext egress path; replaces the
//  ROM-based S-box/ShiftRow/MixColumn/keyExpN chain with one iterative datapath.
//  The key is loaded once and reused for any number of blocks.
// PARAMETERS
//  IO_W      8    beat width of din/dout in bits; legal values 8, 32, 128 (elaboration error otherwise)
//  BEATS     128/IO_W  derived localparam: beats per 128-bit block
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  key_load   in   1      pulse: capture key_in into cipher-key register (honoured only in IDLE)
//  key_in     in   128    cipher key, byte 0 = key_in[127:120]
//  din_valid  in   1      plaintext beat valid
//  din_ready  out  1      plaintext beat accepted when din_valid & din_ready
//  din        in   IO_W   plaintext beat; first beat carries state bytes 0.., MSB = lowest byte index
//  dout_valid out  1      ciphertext beat valid
//  dout_ready in   1      ciphertext beat consumed when dout_valid & dout_ready
//  dout       out  IO_W   ciphertext beat, same byte order as din
//  busy       out  1      high in ROUND and OUT states
// BEHAVIOUR
//  Reset: state=IDLE, beat_cnt=0, rnd=0, state/key/round-key regs=0; din_ready=0, dout_valid=0,
//   dout=0, busy=0. Key reg valid flag kv=0; no block accepted until a key has been loaded.
//  FSM: IDLE -> LOAD when kv=1 (or same cycle key_load captured; LOAD entered next cycle).
//   LOAD: din_ready=1; each handshake shifts din into the 128-bit block reg, beat_cnt++.
//    On the BEATS-th handshake: st <= block ^ key (initial AddRoundKey), rk <= key, rnd <= 1,
//    beat_cnt <= 0, -> ROUND.
//   ROUND: din_ready=0. Each cycle: rk_next = KeyExpand(rk, rcon[rnd]);
//    rnd 1..9: st <= MixColumns(ShiftRows(SubBytes(st))) ^ rk_next;
//    rnd 10:  st <= ShiftRows(SubBytes(st)) ^ rk_next (no MixColumns), -> OUT.
//    rcon: 01,02,04,08,10,20,40,80,1b,36 (xtime per round). S-box is combinational (20 instances:
//    16 data + 4 key SubWord).
//   OUT: dout_valid=1, dout = top IO_W bits of st; each handshake shifts st left by IO_W,
//    beat_cnt++. dout_ready=0 holds dout/dout_valid stable (no beat lost/duplicated).
//    After BEATS-th handshake -> LOAD (kv=1 always here); din_ready rises the following cycle.
//  Latency: dout_valid rises exactly 10 cycles after the clock edge accepting the last din beat.
//   Throughput with IO_W=128 and dout_ready=1: one block per 12 cycles.
//  key_load: captured in IDLE or LOAD only when beat_cnt=0; ignored in ROUND/OUT and mid-block
//   LOAD (partial block never mixes two keys). Captured key takes effect for the next block.
//  din_valid while din_ready=0: ignored, no state change. dout_ready while dout_valid=0: ignored.
//  Reset asserted mid-block or mid-output: all state cleared immediately, partial block discarded,
//   kv=0 (key must be reloaded).
//  Arithmetic: GF(2^8) xtime = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 0); all XORs 128-bit, no carries.
// TESTING
//  1 FIPS-197 C.1, IO_W=8: key 000102..0f, pt 00112233445566778899aabbccddeeff
//    -> dout bytes 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a, first valid 10 cycles after last din.
//  2 FIPS-197 B, IO_W=128: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734
//    -> 3925841d02dc09fbdc118597196a0b32; back-to-back 4 blocks at 12 cycles/block.
//  3 Backpressure IO_W=32: dout_ready random 30% duty -> dout stable while stalled, 4 words exact, din_ready=0 throughout.
//  4 key_load pulse during ROUND with new key -> current block uses old key; next block uses new key.
//  5 No key after reset: din_valid=1 for 50 cycles -> din_ready stays 0; then key_load -> normal C.1 result.
//  6 rst_n low at round 5 -> all outputs 0 asynchronously; after release din_ready=0 until key_load.

Source files
------------

// File: rtl/aes128_iter_enc_stream.sv
// aes128_iter_enc_stream
// Iterative AES-128 encryptor: one full round per clock with on-the-fly key
// expansion. Plaintext is streamed in and ciphertext streamed out as IO_W-bit
// beats over valid/ready handshakes. The cipher key is loaded once and reused
// for any number of blocks. The first beat carries the lowest-index bytes.
module aes128_iter_enc_stream #(
    parameter int IO_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            key_load,
    input  logic [127:0]    key_in,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic [IO_W-1:0] din,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [IO_W-1:0] dout,
    output logic            busy
);

    localparam int         BEATS     = 128 / IO_W;
    localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);

    if (IO_W != 8 && IO_W != 32 && IO_W != 128) begin : g_bad_iow
        $error("aes128_iter_enc_stream: IO_W must be 8, 32 or 128");
    end

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ROUND = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t         state_q;
    logic [4:0]     beat_cnt_q;
    logic [3:0]     rnd_q;
    logic [127:0]   st_q;
    logic [127:0]   rk_q;
    logic [127:0]   key_q;
    logic           kv_q;
    logic           din_ready_q;
    logic           dout_valid_q;
    logic           busy_q;

    logic [127:0]   ld_d;
    logic [127:0]   st_shift_d;
    logic [127:0]   rk_d;
    logic [127:0]   round_d;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte n of the state sits at bits [127-8n -: 8]; row = n%4, column = n/4.
    // SubBytes and ShiftRows fused: output (row, col) takes input (row, col+row).
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rw = 0; rw < 4; rw++) begin
                r[127-8*(4*c+rw) -: 8] = sbox(s[127-8*(4*((c+rw)%4)+rw) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    // One step of the AES-128 key schedule: four new words from the previous four.
    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96];
        w1 = k[95:64];
        w2 = k[63:32];
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Beat shifting: incoming beats enter at the bottom, outgoing beats leave from the top.
    // The state register doubles as the plaintext assembly register during LOAD.
    if (IO_W == 128) begin : g_full_beat
        assign ld_d       = din;
        assign st_shift_d = '0;
    end else begin : g_part_beat
        assign ld_d       = {st_q[127-IO_W:0], din};
        assign st_shift_d = {st_q[127-IO_W:0], {IO_W{1'b0}}};
    end

    // Round datapath: next round key and next state; the last round skips MixColumns.
    always_comb begin
        logic [127:0] ss;
        ss      = sub_shift(st_q);
        rk_d    = key_expand(rk_q, rcon(rnd_q));
        round_d = ((rnd_q == 4'd10) ? ss : mix_columns(ss)) ^ rk_d;
    end

    // Control FSM with registered handshake outputs and the state/key datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            rnd_q        <= '0;
            st_q         <= '0;
            rk_q         <= '0;
            key_q        <= '0;
            kv_q         <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_load) begin
                        key_q <= key_in;
                        kv_q  <= 1'b1;
                    end
                    if (kv_q || key_load) begin
                        state_q     <= S_LOAD;
                        din_ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    // A new key is only taken between blocks; the block closing
                    // on this edge still whitens with the key already held.
                    if (key_load && beat_cnt_q == 5'd0) begin
                        key_q <= key_in;
                    end
                    if (din_valid && din_ready_q) begin
                        if (beat_cnt_q == LAST_BEAT) begin
                            st_q        <= ld_d ^ key_q;
                            rk_q        <= key_q;
                            rnd_q       <= 4'd1;
                            beat_cnt_q  <= '0;
                            state_q     <= S_ROUND;
                            din_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            st_q       <= ld_d;
                            beat_cnt_q <= beat_cnt_q + 5'd1;
                        end
                    end
                end
                S_ROUND: begin
                    st_q <= round_d;
                    rk_q <= rk_d;
                    if (rnd_q == 4'd10) begin
                        rnd_q        <= '0;
                        state_q      <= S_OUT;
                        dout_valid_q <= 1'b1;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                S_OUT: begin
                    if (dout_ready) begin
                        st_q <= st_shift_d;
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q   <= '0;
                            state_q      <= S_LOAD;
                            dout_valid_q <= 1'b0;
                            busy_q       <= 1'b0;
                            din_ready_q  <= 1'b1;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 5'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign din_ready  = din_ready_q;
    assign dout_valid = dout_valid_q;
    assign busy       = busy_q;
    // Plaintext being assembled in the state register is never exposed.
    assign dout       = dout_valid_q ? st_q[127 -: IO_W] : '0;

endmodule

// File: tb/tb_aes128_iter_enc_stream.sv
// tb_aes128_iter_enc_stream
// Directed bench for the iterative AES-128 stream encryptor using the FIPS-197
// vectors, with three instances (IO_W = 8, 32, 128) sharing clock and reset.
module tb_aes128_iter_enc_stream;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    logic         kl_8, dv_8, dr_8, ov_8, ordy_8, busy_8;
    logic [127:0] key_8;
    logic [7:0]   din_8, dout_8;
    logic         kl_32, dv_32, dr_32, ov_32, ordy_32, busy_32;
    logic [127:0] key_32;
    logic [31:0]  din_32, dout_32;
    logic         kl_128, dv_128, dr_128, ov_128, ordy_128, busy_128;
    logic [127:0] key_128;
    logic [127:0] din_128, dout_128;

    aes128_iter_enc_stream #(.IO_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .key_load(kl_8), .key_in(key_8),
        .din_valid(dv_8), .din_ready(dr_8), .din(din_8),
        .dout_valid(ov_8), .dout_ready(ordy_8), .dout(dout_8), .busy(busy_8)
    );

    aes128_iter_enc_stream #(.IO_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .key_load(kl_32), .key_in(key_32),
        .din_valid(dv_32), .din_ready(dr_32), .din(din_32),
        .dout_valid(ov_32), .dout_ready(ordy_32), .dout(dout_32), .busy(busy_32)
    );

    aes128_iter_enc_stream #(.IO_W(128)) u_dut128 (
        .clk(clk), .rst_n(rst_n), .key_load(kl_128), .key_in(key_128),
        .din_valid(dv_128), .din_ready(dr_128), .din(din_128),
        .dout_valid(ov_128), .dout_ready(ordy_128), .dout(dout_128), .busy(busy_128)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        kl_8 = 0; dv_8 = 0; ordy_8 = 0; key_8 = '0; din_8 = '0;
        kl_32 = 0; dv_32 = 0; ordy_32 = 0; key_32 = '0; din_32 = '0;
        kl_128 = 0; dv_128 = 0; ordy_128 = 0; key_128 = '0; din_128 = '0;
        #1 rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({dr_8, ov_8, busy_8, dout_8} !== 11'b0) begin
            failures++; $display("FAIL reset_8: got %b expected 0", {dr_8, ov_8, busy_8, dout_8});
        end
        checks++;
        if ({dr_32, ov_32, busy_32, dout_32} !== 35'b0) begin
            failures++; $display("FAIL reset_32: got %h expected 0", {dr_32, ov_32, busy_32, dout_32});
        end
        checks++;
        if ({dr_128, ov_128, busy_128, dout_128} !== 131'b0) begin
            failures++; $display("FAIL reset_128: got %h expected 0", {dr_128, ov_128, busy_128, dout_128});
        end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({dr_8, dr_32, dr_128} !== 3'b000) begin
            failures++; $display("FAIL ready_after_reset: got %b expected 000", {dr_8, dr_32, dr_128});
        end
    endtask

    task automatic test_no_key();
        dv_8 = 1; din_8 = 8'ha5;
        for (int c = 0; c < 50; c++) begin
            checks++;
            if (dr_8 !== 1'b0) begin
                failures++; $display("FAIL no_key_ready cycle %0d: got %b expected 0", c, dr_8);
            end
            tick();
        end
        dv_8 = 0;
        checks++;
        if ({ov_8, busy_8} !== 2'b00) begin
            failures++; $display("FAIL no_key_idle: got %b expected 00", {ov_8, busy_8});
        end
    endtask

    task automatic test_c1_iow8();
        logic [127:0] pt, ct;
        pt = PT_C1; ct = CT_C1;
        kl_8 = 1; key_8 = KEY_C1; tick(); kl_8 = 0;
        checks++;
        if (dr_8 !== 1'b1) begin
            failures++; $display("FAIL c1_ready_after_key: got %b expected 1", dr_8);
        end
        for (int i = 0; i < 16; i++) begin
            dv_8 = 1; din_8 = pt[127-8*i -: 8]; tick();
        end
        dv_8 = 0;
        checks++;
        if ({busy_8, dr_8} !== 2'b10) begin
            failures++; $display("FAIL c1_busy: got busy,ready=%b expected 10", {busy_8, dr_8});
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (ov_8 !== 1'(k == 10)) begin
                failures++; $display("FAIL c1_latency cycle %0d: got valid=%b expected %b", k, ov_8, (k == 10));
            end
        end
        ordy_8 = 1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ov_8 !== 1'b1 || dout_8 !== ct[127-8*i -: 8]) begin
                failures++; $display("FAIL c1_byte %0d: got valid=%b %h expected %h", i, ov_8, dout_8, ct[127-8*i -: 8]);
            end
            tick();
        end
        ordy_8 = 0;
        checks++;
        if ({ov_8, busy_8, dr_8} !== 3'b001) begin
            failures++; $display("FAIL c1_after_out: got valid,busy,ready=%b expected 001", {ov_8, busy_8, dr_8});
        end
    endtask

    task automatic test_back_to_back();
        int in_c[4];
        int out_c[4];
        int n_in, n_out;
        for (int k = 0; k < 4; k++) begin in_c[k] = -100; out_c[k] = -100; end
        kl_128 = 1; key_128 = KEY_B; tick(); kl_128 = 0;
        ordy_128 = 1; dv_128 = 1; din_128 = PT_B; n_in = 0; n_out = 0;
        for (int c = 0; c < 60; c++) begin
            if (n_in == 4) dv_128 = 0;
            if (dv_128 && dr_128 === 1'b1) begin in_c[n_in] = c; n_in++; end
            if (ov_128 === 1'b1) begin
                checks++;
                if (dout_128 !== CT_B) begin
                    failures++; $display("FAIL b2b_data cycle %0d: got %h expected %h", c, dout_128, CT_B);
                end
                if (n_out < 4) out_c[n_out] = c;
                n_out++;
            end
            tick();
        end
        ordy_128 = 0; dv_128 = 0;
        checks++;
        if (n_in != 4 || n_out != 4) begin
            failures++; $display("FAIL b2b_counts: got in=%0d out=%0d expected 4 4", n_in, n_out);
        end
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (in_c[k] - in_c[k-1] != 12 || out_c[k] - out_c[k-1] != 12) begin
                failures++; $display("FAIL b2b_period %0d: got in=%0d out=%0d expected 12 12", k, in_c[k] - in_c[k-1], out_c[k] - out_c[k-1]);
            end
        end
        checks++;
        if (out_c[0] - in_c[0] != 11) begin
            failures++; $display("FAIL b2b_latency: got %0d expected 11", out_c[0] - in_c[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] pt, ct;
        logic [31:0]  prev;
        logic         stalled;
        int           n, guard;
        pt = PT_C1; ct = CT_C1;
        kl_32 = 1; key_32 = KEY_C1; tick(); kl_32 = 0;
        for (int i = 0; i < 4; i++) begin
            dv_32 = 1; din_32 = pt[127-32*i -: 32]; tick();
        end
        dv_32 = 0;
        guard = 0;
        while (ov_32 !== 1'b1 && guard < 20) begin
            checks++;
            if (dr_32 !== 1'b0) begin
                failures++; $display("FAIL bp_ready_in_round: got %b expected 0", dr_32);
            end
            tick(); guard++;
        end
        checks++;
        if (ov_32 !== 1'b1) begin
            failures++; $display("FAIL bp_valid_timeout: got %b expected 1", ov_32);
        end
        n = 0; guard = 0; stalled = 0; prev = '0;
        dv_32 = 1; din_32 = 32'hdeadbeef;
        while (n < 4 && guard < 300) begin
            ordy_32 = ($urandom_range(0, 9) < 3);
            if (ov_32 === 1'b1) begin
                if (stalled) begin
                    checks++;
                    if (dout_32 !== prev) begin
                        failures++; $display("FAIL bp_hold: got %h expected %h", dout_32, prev);
                    end
                end
                checks++;
                if (dr_32 !== 1'b0) begin
                    failures++; $display("FAIL bp_ready_in_out: got %b expected 0", dr_32);
                end
                if (ordy_32) begin
                    checks++;
                    if (dout_32 !== ct[127-32*n -: 32]) begin
                        failures++; $display("FAIL bp_word %0d: got %h expected %h", n, dout_32, ct[127-32*n -: 32]);
                    end
                    n++; stalled = 0;
                end else begin
                    stalled = 1; prev = dout_32;
                end
            end
            tick(); guard++;
        end
        ordy_32 = 0; dv_32 = 0;
        checks++;
        if (n != 4 || ov_32 !== 1'b0 || dr_32 !== 1'b1) begin
            failures++; $display("FAIL bp_end: got words=%0d valid=%b ready=%b expected 4 0 1", n, ov_32, dr_32);
        end
    endtask

    task automatic test_key_during_round();
        int guard;
        checks++;
        if (dr_128 !== 1'b1) begin
            failures++; $display("FAIL kr_ready_start: got %b expected 1", dr_128);
        end
        dv_128 = 1; din_128 = PT_B; tick(); dv_128 = 0;
        repeat (3) tick();
        kl_128 = 1; key_128 = KEY_C1; tick(); kl_128 = 0;
        guard = 0;
        while (ov_128 !== 1'b1 && guard < 20) begin tick(); guard++; end
        checks++;
        if (ov_128 !== 1'b1 || dout_128 !== CT_B) begin
            failures++; $display("FAIL kr_old_key: got valid=%b %h expected %h", ov_128, dout_128, CT_B);
        end
        ordy_128 = 1; tick(); ordy_128 = 0;
        checks++;
        if (dr_128 !== 1'b1) begin
            failures++; $display("FAIL kr_ready_after_out: got %b expected 1", dr_128);
        end
        kl_128 = 1; key_128 = KEY_C1; tick(); kl_128 = 0;
        dv_128 = 1; din_128 = PT_C1; tick(); dv_128 = 0;
        guard = 0;
        while (ov_128 !== 1'b1 && guard < 20) begin tick(); guard++; end
        checks++;
        if (ov_128 !== 1'b1 || dout_128 !== CT_C1) begin
            failures++; $display("FAIL kr_new_key: got valid=%b %h expected %h", ov_128, dout_128, CT_C1);
        end
        ordy_128 = 1; tick(); ordy_128 = 0;
        checks++;
        if (ov_128 !== 1'b0) begin
            failures++; $display("FAIL kr_valid_drop: got %b expected 0", ov_128);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt;
        pt = PT_C1;
        for (int i = 0; i < 16; i++) begin
            dv_8 = 1; din_8 = pt[127-8*i -: 8]; tick();
        end
        dv_8 = 0;
        repeat (5) tick();
        checks++;
        if (busy_8 !== 1'b1) begin
            failures++; $display("FAIL rm_busy_before: got %b expected 1", busy_8);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dr_8, ov_8, busy_8, dout_8} !== 11'b0) begin
            failures++; $display("FAIL rm_async_clear: got %b expected 0", {dr_8, ov_8, busy_8, dout_8});
        end
        checks++;
        if ({dr_32, dr_128} !== 2'b00) begin
            failures++; $display("FAIL rm_others_clear: got %b expected 00", {dr_32, dr_128});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        dv_8 = 1; din_8 = 8'h3c;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (dr_8 !== 1'b0) begin
                failures++; $display("FAIL rm_no_key_ready cycle %0d: got %b expected 0", c, dr_8);
            end
        end
        dv_8 = 0;
        kl_8 = 1; key_8 = KEY_C1; tick(); kl_8 = 0;
        checks++;
        if (dr_8 !== 1'b1) begin
            failures++; $display("FAIL rm_reload_ready: got %b expected 1", dr_8);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_no_key();
        test_c1_iow8();
        test_back_to_back();
        test_backpressure();
        test_key_during_round();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
